pc_redirect_ctrl: RTL

//  Arbitrates and sequences every PC redirect into the fetch PC register: trap (from MEM), branch (from EXC) and BPU prediction.

---
 rtl/pc_redirect_if.sv | 36 +++
 rtl/pc_redirect_ctrl.sv | 66 ++++++
 2 files changed

// File: rtl/pc_redirect_if.sv
// pc_redirect_if: redirect request / fetch redirect bundle between the redirect sources, pc_reg and pc_redirect_ctrl.
// Requests (master -> slave):
//   trap_valid/trap_pc, branch_valid/branch_pc, bpu_valid/bpu_pc : redirect requests, priority trap > branch > bpu
//   pc_stall                                                     : pc_reg did not consume the redirect this cycle
// Responses (slave -> master):
//   redirect_valid/redirect_pc/redirect_src : registered redirect slot (src 0=none 1=bpu 2=branch 3=trap)
//   flush_if/flush_id                       : stage flushes
//   epoch                                   : current fetch epoch
//   misalign                                : one-cycle pulse, captured target had bit0 set
interface pc_redirect_if #(
   parameter int ADDR_W  = 32,
   parameter int EPOCH_W = 2
);
   logic               trap_valid;
   logic [ADDR_W-1:0]  trap_pc;
   logic               branch_valid;
   logic [ADDR_W-1:0]  branch_pc;
   logic               bpu_valid;
   logic [ADDR_W-1:0]  bpu_pc;
   logic               pc_stall;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic [1:0]         redirect_src;
   logic               flush_if;
   logic               flush_id;
   logic [EPOCH_W-1:0] epoch;
   logic               misalign;
   modport master (
      output trap_valid, trap_pc, branch_valid, branch_pc, bpu_valid, bpu_pc, pc_stall,
      input  redirect_valid, redirect_pc, redirect_src, flush_if, flush_id, epoch, misalign
   );
   modport slave (
      input  trap_valid, trap_pc, branch_valid, branch_pc, bpu_valid, bpu_pc, pc_stall,
      output redirect_valid, redirect_pc, redirect_src, flush_if, flush_id, epoch, misalign
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates trap/branch/bpu redirects into one registered slot for pc_reg, raises IF/ID flushes and bumps the fetch epoch.
// Ports:
//   clk : clock
//   rst : synchronous reset, active low
//   rd  : pc_redirect_if slave (requests and pc_stall in; slot, flushes, epoch, misalign out)
module pc_redirect_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int EPOCH_W      = 2,
   parameter int FLUSH_CYCLES = 1
) (
   input logic          clk,
   input logic          rst,
   pc_redirect_if.slave rd
);
   typedef enum logic {IDLE, PEND} state_t;
   state_t             state, state_nx;
   logic [ADDR_W-1:0]  slot_pc;
   logic [1:0]         slot_src;
   logic [EPOCH_W-1:0] epoch;
   logic [2:0]         flush_cnt;
   logic               flush_id_q;
   logic               misalign_q;
   logic [1:0]         win_src;
   logic [ADDR_W-1:0]  win_pc;
   logic               accept;
   logic               capture;
   // Source codes double as priorities, so a stalled slot is overwritten by any winner of equal or higher rank.
   always_comb begin
      win_src  = rd.trap_valid ? 2'd3 : rd.branch_valid ? 2'd2 : rd.bpu_valid ? 2'd1 : 2'd0;
      win_pc   = rd.trap_valid ? rd.trap_pc : rd.branch_valid ? rd.branch_pc : rd.bpu_pc;
      accept   = (state == PEND) && !rd.pc_stall;
      capture  = (win_src != 2'd0) && ((state == IDLE) || accept || (win_src >= slot_src));
      state_nx = capture ? PEND : accept ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         slot_pc    <= '0;
         slot_src   <= '0;
         epoch      <= '0;
         flush_cnt  <= '0;
         flush_id_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state      <= state_nx;
         epoch      <= epoch + EPOCH_W'(accept);
         misalign_q <= capture && win_pc[0];
         if (capture) begin
            slot_pc    <= {win_pc[ADDR_W-1:1], 1'b0};
            slot_src   <= win_src;
            flush_cnt  <= 3'(FLUSH_CYCLES);
            // An ID flush already in progress is never downgraded by a bpu reload.
            flush_id_q <= win_src[1] | ((flush_cnt != 3'd0) && flush_id_q);
         end else if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
         end
      end
   end
   assign rd.redirect_valid = (state == PEND);
   assign rd.redirect_pc    = (state == PEND) ? slot_pc : '0;
   assign rd.redirect_src   = (state == PEND) ? slot_src : 2'd0;
   assign rd.flush_if       = (flush_cnt != 3'd0);
   assign rd.flush_id       = (flush_cnt != 3'd0) && flush_id_q;
   assign rd.epoch          = epoch;
   assign rd.misalign       = misalign_q;
endmodule
